tl_uh_mem_arbiter: RTL



---
 rtl/tl_uh_mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tl_uh_mem_arbiter.sv
// Round-robin arbiter sharing one TL-UH memory port (A/D channels) between N uncached masters.
// Multi-beat Put bursts and stalled first beats keep the selection locked; D responses route on the source tag.
module tl_uh_mem_arbiter #(
    parameter int  N        = 2,
    parameter int  ADDR_W   = 64,
    parameter int  DATA_W   = 64,
    parameter int  SOURCE_W = 4,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [N-1:0]              m_a_valid_i,
    output logic [N-1:0]              m_a_ready_o,
    input  logic [3*N-1:0]            m_a_opcode_i,
    input  logic [3*N-1:0]            m_a_param_i,
    input  logic [3*N-1:0]            m_a_size_i,
    input  logic [N*SOURCE_W-1:0]     m_a_source_i,
    input  logic [N*ADDR_W-1:0]       m_a_address_i,
    input  logic [8*N-1:0]            m_a_mask_i,
    input  logic [N*DATA_W-1:0]       m_a_data_i,

    output logic [N-1:0]              m_d_valid_o,
    input  logic [N-1:0]              m_d_ready_i,
    output logic [2:0]                m_d_opcode_o,
    output logic [1:0]                m_d_param_o,
    output logic [2:0]                m_d_size_o,
    output logic [SOURCE_W-1:0]       m_d_source_o,
    output logic [1:0]                m_d_sink_o,
    output logic                      m_d_denied_o,
    output logic                      m_d_corrupt_o,
    output logic [DATA_W-1:0]         m_d_data_o,

    output logic                      mem_a_valid_o,
    input  logic                      mem_a_ready_i,
    output logic [2:0]                mem_a_opcode_o,
    output logic [2:0]                mem_a_param_o,
    output logic [2:0]                mem_a_size_o,
    output logic [SOURCE_W+IDX_W-1:0] mem_a_source_o,
    output logic [ADDR_W-1:0]         mem_a_address_o,
    output logic [7:0]                mem_a_mask_o,
    output logic [DATA_W-1:0]         mem_a_data_o,

    input  logic                      mem_d_valid_i,
    output logic                      mem_d_ready_o,
    input  logic [2:0]                mem_d_opcode_i,
    input  logic [1:0]                mem_d_param_i,
    input  logic [2:0]                mem_d_size_i,
    input  logic [SOURCE_W+IDX_W-1:0] mem_d_source_i,
    input  logic [1:0]                mem_d_sink_i,
    input  logic                      mem_d_denied_i,
    input  logic                      mem_d_corrupt_i,
    input  logic [DATA_W-1:0]         mem_d_data_i
);

    // state | meaning
    // IDLE  | round-robin selection from rr_ptr, no message in flight
    // HOLD  | first beat presented but stalled; selection frozen on grant_q
    // BURST | multi-beat Put in progress; selection locked on grant_q
    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_q;
    logic [2:0]       beat_cnt;

    logic [IDX_W-1:0] rr_sel;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [IDX_W-1:0] sel;
    logic [2:0]       sel_opcode;
    logic [2:0]       sel_size;
    logic             a_fire;
    logic             is_burst;
    logic [3:0]       burst_beats;
    logic [IDX_W-1:0] d_idx;

    always_comb begin
        rr_sel = rr_ptr;
        cand   = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!found && m_a_valid_i[cand]) begin
                rr_sel = cand;
                found  = 1'b1;
            end
        end
    end

    assign sel        = (state == IDLE) ? rr_sel : grant_q;
    assign sel_opcode = m_a_opcode_i[3*int'(sel) +: 3];
    assign sel_size   = m_a_size_i[3*int'(sel) +: 3];

    assign mem_a_valid_o   = m_a_valid_i[sel];
    assign mem_a_opcode_o  = sel_opcode;
    assign mem_a_param_o   = m_a_param_i[3*int'(sel) +: 3];
    assign mem_a_size_o    = sel_size;
    assign mem_a_source_o  = {sel, m_a_source_i[SOURCE_W*int'(sel) +: SOURCE_W]};
    assign mem_a_address_o = m_a_address_i[ADDR_W*int'(sel) +: ADDR_W];
    assign mem_a_mask_o    = m_a_mask_i[8*int'(sel) +: 8];
    assign mem_a_data_o    = m_a_data_i[DATA_W*int'(sel) +: DATA_W];

    always_comb begin
        m_a_ready_o      = '0;
        m_a_ready_o[sel] = mem_a_ready_i & mem_a_valid_o;
    end

    assign a_fire      = mem_a_valid_o & mem_a_ready_i;
    assign is_burst    = ((sel_opcode == OP_PUT_FULL) || (sel_opcode == OP_PUT_PARTIAL)) &&
                         (sel_size > 3'd3);
    // 8-byte beats: a burst of 2^size bytes carries 2^(size-3) beats
    assign burst_beats = 4'd1 << (sel_size - 3'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (a_fire) begin
                        if (is_burst) begin
                            state    <= BURST;
                            grant_q  <= sel;
                            beat_cnt <= 3'(burst_beats - 4'd1);
                        end else begin
                            state  <= IDLE;
                            rr_ptr <= sel + IDX_W'(1);
                        end
                    end else if (mem_a_valid_o) begin
                        state   <= HOLD;
                        grant_q <= sel;
                    end
                end
                BURST: begin
                    if (a_fire) begin
                        beat_cnt <= beat_cnt - 3'd1;
                        if (beat_cnt == 3'd1) begin
                            state  <= IDLE;
                            rr_ptr <= grant_q + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // D path needs no state: the upper source bits name the requesting master
    assign d_idx = mem_d_source_i[SOURCE_W +: IDX_W];

    always_comb begin
        m_d_valid_o        = '0;
        m_d_valid_o[d_idx] = mem_d_valid_i;
    end

    assign mem_d_ready_o = m_d_ready_i[d_idx];
    assign m_d_opcode_o  = mem_d_opcode_i;
    assign m_d_param_o   = mem_d_param_i;
    assign m_d_size_o    = mem_d_size_i;
    assign m_d_source_o  = mem_d_source_i[SOURCE_W-1:0];
    assign m_d_sink_o    = mem_d_sink_i;
    assign m_d_denied_o  = mem_d_denied_i;
    assign m_d_corrupt_o = mem_d_corrupt_i;
    assign m_d_data_o    = mem_d_data_i;

endmodule
